// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and encodings for the MIPS core
package mips_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
  localparam logic [31:0] INSTR_HALT = 32'hFC00_0000;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with hold/increment/load next-PC mux
module pc_unit
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [1:0]            i_sel,
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus1
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Modulo-2^ADDR_WIDTH increment: the top address wraps to zero.
  assign o_pc_plus1 = pc_q + ADDR_WIDTH'(1);
  assign o_pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel_e'(i_sel))
      PC_INC:  pc_d = o_pc_plus1;
      PC_LOAD: pc_d = i_target;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: fetch FSM, IF/ID register, fetch counter
module if_stage
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  output logic                  o_imem_valid,
  output logic [ADDR_WIDTH-1:0] o_imem_address,
  input  logic [DATA_WIDTH-1:0] i_imem_data,
  input  logic                  i_imem_halt,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_ifid_instr,
  output logic [ADDR_WIDTH-1:0] o_ifid_pc_next,
  output logic                  o_ifid_valid,
  output logic                  o_halted,
  output logic [15:0]           o_fetch_count
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [1:0]            pc_sel;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  redirect;

  logic                  ifid_we;
  logic [DATA_WIDTH-1:0] ifid_instr_d;
  logic [ADDR_WIDTH-1:0] ifid_pc_next_d;
  logic                  ifid_valid_d;

  assign redirect        = i_branch_taken | i_jump;
  assign redirect_target = i_branch_taken ? i_branch_target : i_jump_target;

  pc_unit #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_unit (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sel     (pc_sel),
    .i_target  (redirect_target),
    .o_pc      (pc),
    .o_pc_plus1(pc_plus1)
  );

  assign o_pc           = pc;
  assign o_imem_address = pc;
  assign o_halted       = (state_q == ST_HALTED);
  assign o_imem_valid   = i_valid & (state_q == ST_FETCH);

  always_comb begin
    state_d        = state_q;
    pc_sel         = PC_HOLD;
    ifid_we        = 1'b0;
    ifid_instr_d   = DATA_WIDTH'(INSTR_NOP);
    ifid_pc_next_d = '0;
    ifid_valid_d   = 1'b0;
    if (i_valid) begin
      if (redirect) begin
        // Redirect squashes whatever was fetched and also pulls us out of HALTED.
        pc_sel  = PC_LOAD;
        ifid_we = 1'b1;
        state_d = ST_FETCH;
      end else if (i_stall) begin
        pc_sel = PC_HOLD;
      end else if (state_q == ST_FETCH) begin
        ifid_we        = 1'b1;
        ifid_pc_next_d = pc_plus1;
        ifid_valid_d   = 1'b1;
        if (i_imem_halt) begin
          ifid_instr_d = DATA_WIDTH'(INSTR_HALT);
          state_d      = ST_HALTED;
        end else begin
          ifid_instr_d = i_imem_data;
          pc_sel       = PC_INC;
        end
      end else begin
        ifid_we = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_FETCH;
      o_ifid_instr   <= DATA_WIDTH'(INSTR_NOP);
      o_ifid_pc_next <= '0;
      o_ifid_valid   <= 1'b0;
      o_fetch_count  <= '0;
    end else begin
      state_q <= state_d;
      if (ifid_we) begin
        o_ifid_instr   <= ifid_instr_d;
        o_ifid_pc_next <= ifid_pc_next_d;
        o_ifid_valid   <= ifid_valid_d;
        if (ifid_valid_d && o_fetch_count != 16'hFFFF) begin
          o_fetch_count <= o_fetch_count + 16'd1;
        end
      end
    end
  end

endmodule
